ddr_frame_scheduler: RTL and testbench
======================================

# ddr_frame_scheduler

Sequences DDR burst traffic between the camera write FIFO and the VGA read FIFO in the capture-to-display path, in the DDR user clock domain. It arbitrates burst grants between the two directions and issues burst commands to the DDR controller. It manages a triple frame buffer, so the display always reads the most recently completed camera frame and the camera never writes the buffer being displayed.

## Interface
- ADDR_W, 25, word address width of cmd_addr.
- BURST_LEN, 64, 32-bit words per burst; power of two.
- FRAME_WORDS, 393216, words per frame; must be a multiple of BURST_LEN.
- FRAME_STRIDE, 524288, word spacing between buffer bases; must be ≥ FRAME_WORDS.
- clk  in  1  DDR user clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ddr_init_done  in  1  controller calibrated; no commands or frame events while low.
- wr_fifo_level  in  16  words currently stored in the write FIFO.
- rd_fifo_space  in  16  free words in the read FIFO.
- vin_vs_pulse  in  1  one-cycle camera frame start, already synchronized to clk.
- vout_vs_pulse  in  1  one-cycle display frame start, already synchronized to clk.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  controller accepts the command when high with cmd_valid.
- cmd_write  out  1  1 = write burst (FIFO→DDR), 0 = read burst.
- cmd_addr  out  ADDR_W  burst start word address, buf*FRAME_STRIDE + offset.
- cmd_len  out  8  equals BURST_LEN-1.
- burst_done  in  1  one-cycle pulse when the accepted burst's data has fully moved.
- wr_buf  out  2  buffer index (0..2) being written.
- rd_buf  out  2  buffer index (0..2) being read.
- frame_write_done  out  1  one-cycle pulse when a full frame is written.
- frame_read_done  out  1  one-cycle pulse when a full frame is read.

## Operation
- FSM states:
  - IDLE: evaluate eligibility and grant.
  - CMD: cmd_valid=1; go to WAIT on cmd_ready.
  - WAIT: wait for burst_done, then return to IDLE.
- Write eligible: wr_active and wr_cnt<FRAME_WORDS and wr_fifo_level≥BURST_LEN.
- Read eligible: rd_active and rd_cnt<FRAME_WORDS and rd_fifo_space≥BURST_LEN.
- Arbitration in IDLE:
  - One direction eligible: grant it.
  - Both eligible: round-robin. Grant the direction opposite last_grant; last_grant resets to read, so the first contested grant goes to write.
- Grant latches cmd_write and cmd_addr.
- On burst_done in WAIT: the granted counter (wr_cnt or rd_cnt) adds BURST_LEN.
  - If the counter reaches FRAME_WORDS, pulse that direction's done output.
  - On write completion also set last_done_buf=wr_buf and frame_valid=1.
- Frame events are latched as pending and applied only in IDLE; no in-flight burst is ever aborted.
- Pending vout applied:
  - If frame_valid: rd_buf=last_done_buf, rd_cnt=0, rd_active=1.
  - Otherwise the event is discarded and rd_active stays 0.
- Pending vin applied:
  - wr_buf = lowest index not equal to rd_buf (post-update value) and not equal to last_done_buf.
  - wr_cnt=0, wr_active=1.
  - A partially written frame is abandoned; last_done_buf is unchanged.
- Both pending in the same IDLE cycle: apply vout first, then vin. Both are applied in that cycle, and no grant is made that cycle.
- A vs pulse arriving in the same cycle a pending flag clears re-sets the flag; no event is lost.
- ddr_init_done low: FSM held in IDLE, vs pulses ignored. If it falls while in CMD or WAIT, the transaction completes first.
- burst_done outside WAIT: ignored.
- Reset values:
  - FSM IDLE; cmd_valid=0, cmd_write=0, cmd_addr=0.
  - wr_buf=1, rd_buf=0, last_done_buf=0.
  - frame_valid=0, wr_active=0, rd_active=0, counters 0.
  - All done pulses 0; pending flags cleared.

## Timing
- IDLE grant → cmd_valid high on the next cycle.
- cmd_valid, cmd_write and cmd_addr stay stable until the cmd_ready handshake.
- Minimum grant-to-grant spacing: 3 cycles (IDLE, CMD with ready=1, WAIT with immediate burst_done).
- frame_*_done pulses are registered: high the cycle after burst_done is sampled in WAIT.
- wr_buf and rd_buf update the cycle after the pending event is applied in IDLE.
- Reset asserted mid-burst: all state returns to reset values on that edge; the outstanding burst_done is ignored.

## Configuration
- READ_PRIORITY_EN defined: when both directions are eligible, read always wins (display underrun protection); last_grant is unused.
- READ_PRIORITY_EN undefined: round-robin as described in Operation.

## Test plan
Bench parameters for all scenarios: BURST_LEN=4, FRAME_WORDS=16, FRAME_STRIDE=32.
- Basic write frame:
  - Stimulus: reset, init_done=1, vin pulse, wr_fifo_level=8, cmd_ready=1, burst_done 2 cycles after each accept.
  - Response: 4 write commands at addresses 32, 36, 40, 44; frame_write_done once; last_done_buf=1.
- Read frame selection:
  - Stimulus: complete a write frame, then vout pulse.
  - Response: rd_buf=1; read commands at addresses 32..44; frame_read_done after the 4th burst_done.
- Triple buffer rotation:
  - Stimulus: rd_buf=1, last_done_buf=1, vin pulse.
  - Response: wr_buf=0; after that frame completes and a new vin pulse arrives, wr_buf=2.
- Round-robin:
  - Stimulus: both directions continuously eligible.
  - Response: grants alternate W,R,W,R starting with W. With READ_PRIORITY_EN defined: all R until rd_cnt=16.
- Event boundaries:
  - Stimulus: vin and vout pulses arriving together during WAIT; cmd_ready held low for 5 cycles.
  - Response: command stays stable through the stall; both events applied in the IDLE after burst_done, vout first.
- Reset and init gating:
  - Stimulus: rst_n low during WAIT; separately, ddr_init_done=0 with a vin pulse.
  - Response: outputs return to reset values the next cycle; no cmd_valid and wr_active stays 0.

Source files
------------

// File: rtl/ddr_frame_scheduler.sv
// Burst scheduler between camera write FIFO and VGA read FIFO with triple frame buffering.
// Define READ_PRIORITY_EN to let reads always win contested grants instead of round-robin.
module ddr_frame_scheduler #(
  parameter int ADDR_W       = 25,
  parameter int BURST_LEN    = 64,
  parameter int FRAME_WORDS  = 393216,
  parameter int FRAME_STRIDE = 524288
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ddr_init_done,
  input  logic [15:0]       wr_fifo_level,
  input  logic [15:0]       rd_fifo_space,
  input  logic              vin_vs_pulse,
  input  logic              vout_vs_pulse,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  input  logic              burst_done,
  output logic [1:0]        wr_buf,
  output logic [1:0]        rd_buf,
  output logic              frame_write_done,
  output logic              frame_read_done
);

  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [15:0]       BURST_LVL = 16'(BURST_LEN);
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(FRAME_STRIDE);

  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [1:0]        last_done_buf;
  logic              frame_valid;
  logic              wr_active;
  logic              rd_active;
  logic              vin_pend;
  logic              vout_pend;
`ifndef READ_PRIORITY_EN
  logic              last_grant_wr;
`endif

  logic              wr_elig;
  logic              rd_elig;
  logic              grant_wr;
  logic              idle_ready;
  logic              do_grant;
  logic              burst_complete;
  logic [1:0]        rd_buf_new;
  logic [1:0]        wr_buf_free;
  logic [ADDR_W-1:0] grant_addr;

  assign cmd_len = 8'(BURST_LEN - 1);

  always_comb begin
    wr_elig    = wr_active && (wr_cnt < FRAME_CNT) && (wr_fifo_level >= BURST_LVL);
    rd_elig    = rd_active && (rd_cnt < FRAME_CNT) && (rd_fifo_space >= BURST_LVL);
`ifdef READ_PRIORITY_EN
    grant_wr   = wr_elig && !rd_elig;
`else
    grant_wr   = wr_elig && (!rd_elig || !last_grant_wr);
`endif
    idle_ready = (state == IDLE) && ddr_init_done;
    // Pending frame events take the whole IDLE cycle; the grant waits one cycle.
    do_grant   = idle_ready && !vin_pend && !vout_pend && (wr_elig || rd_elig);
    burst_complete = (state == WAIT) && burst_done;
    grant_addr = grant_wr ? (ADDR_W'(wr_buf) * STRIDE + ADDR_W'(wr_cnt))
                          : (ADDR_W'(rd_buf) * STRIDE + ADDR_W'(rd_cnt));
  end

  // New write buffer must avoid both the buffer about to be displayed and the last complete frame.
  always_comb begin
    rd_buf_new = (vout_pend && frame_valid) ? last_done_buf : rd_buf;
    if ((rd_buf_new != 2'd0) && (last_done_buf != 2'd0))
      wr_buf_free = 2'd0;
    else if ((rd_buf_new != 2'd1) && (last_done_buf != 2'd1))
      wr_buf_free = 2'd1;
    else
      wr_buf_free = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (do_grant)       state_next = CMD;
      CMD:     if (cmd_ready)      state_next = WAIT;
      WAIT:    if (burst_done)     state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (state == CMD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_write        <= 1'b0;
      cmd_addr         <= '0;
      wr_buf           <= 2'd1;
      rd_buf           <= 2'd0;
      last_done_buf    <= 2'd0;
      frame_valid      <= 1'b0;
      wr_active        <= 1'b0;
      rd_active        <= 1'b0;
      wr_cnt           <= '0;
      rd_cnt           <= '0;
      vin_pend         <= 1'b0;
      vout_pend        <= 1'b0;
      frame_write_done <= 1'b0;
      frame_read_done  <= 1'b0;
`ifndef READ_PRIORITY_EN
      last_grant_wr    <= 1'b0;
`endif
    end else begin
      frame_write_done <= 1'b0;
      frame_read_done  <= 1'b0;
      vin_pend  <= (vin_pend  && !idle_ready) || (vin_vs_pulse  && ddr_init_done);
      vout_pend <= (vout_pend && !idle_ready) || (vout_vs_pulse && ddr_init_done);

      if (idle_ready) begin
        if (vout_pend && frame_valid) begin
          rd_buf    <= last_done_buf;
          rd_cnt    <= '0;
          rd_active <= 1'b1;
        end
        if (vin_pend) begin
          wr_buf    <= wr_buf_free;
          wr_cnt    <= '0;
          wr_active <= 1'b1;
        end
      end

      if (do_grant) begin
        cmd_write     <= grant_wr;
        cmd_addr      <= grant_addr;
`ifndef READ_PRIORITY_EN
        last_grant_wr <= grant_wr;
`endif
      end

      if (burst_complete) begin
        if (cmd_write) begin
          wr_cnt <= wr_cnt + BURST_CNT;
          if ((wr_cnt + BURST_CNT) == FRAME_CNT) begin
            frame_write_done <= 1'b1;
            last_done_buf    <= wr_buf;
            frame_valid      <= 1'b1;
          end
        end else begin
          rd_cnt <= rd_cnt + BURST_CNT;
          if ((rd_cnt + BURST_CNT) == FRAME_CNT)
            frame_read_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_frame_scheduler.sv
// Self-checking bench for ddr_frame_scheduler: directed scenarios plus randomized traffic
// checked against a transaction-level frame-buffer model.
module tb_ddr_frame_scheduler;

  localparam int BL = 4;
  localparam int FW = 16;
  localparam int FS = 32;

  logic        clk;
  logic        rst_n;
  logic        ddr_init_done;
  logic [15:0] wr_fifo_level;
  logic [15:0] rd_fifo_space;
  logic        vin_vs_pulse;
  logic        vout_vs_pulse;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [24:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        burst_done;
  logic [1:0]  wr_buf;
  logic [1:0]  rd_buf;
  logic        frame_write_done;
  logic        frame_read_done;

  int checks = 0;
  int errors = 0;
  int wr_level = 0;
  int rd_level = 0;

  int m_wr_buf, m_rd_buf, m_last_done, m_wr_cnt, m_rd_cnt;
  bit m_frame_valid, m_wr_active, m_rd_active, m_last_wr;

  ddr_frame_scheduler #(
    .ADDR_W(25), .BURST_LEN(BL), .FRAME_WORDS(FW), .FRAME_STRIDE(FS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ddr_init_done(ddr_init_done),
    .wr_fifo_level(wr_fifo_level), .rd_fifo_space(rd_fifo_space),
    .vin_vs_pulse(vin_vs_pulse), .vout_vs_pulse(vout_vs_pulse),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .burst_done(burst_done),
    .wr_buf(wr_buf), .rd_buf(rd_buf),
    .frame_write_done(frame_write_done), .frame_read_done(frame_read_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Frame-buffer model: buffers, counters and arbitration follow the block's rules directly.
  function automatic void model_reset();
    m_wr_buf = 1; m_rd_buf = 0; m_last_done = 0;
    m_wr_cnt = 0; m_rd_cnt = 0;
    m_frame_valid = 0; m_wr_active = 0; m_rd_active = 0; m_last_wr = 0;
  endfunction

  function automatic void model_vout();
    if (m_frame_valid) begin
      m_rd_buf = m_last_done; m_rd_cnt = 0; m_rd_active = 1;
    end
  endfunction

  function automatic void model_vin();
    for (int b = 2; b >= 0; b--)
      if (b != m_rd_buf && b != m_last_done) m_wr_buf = b;
    m_wr_cnt = 0; m_wr_active = 1;
  endfunction

  function automatic int model_grant(output int addr);
    bit we, re;
    int g;
    we = m_wr_active && (m_wr_cnt < FW) && (wr_level >= BL);
    re = m_rd_active && (m_rd_cnt < FW) && (rd_level >= BL);
    if (we && re) begin
`ifdef READ_PRIORITY_EN
      g = 0;
`else
      g = m_last_wr ? 0 : 1;
`endif
    end else if (we) g = 1;
    else if (re)     g = 0;
    else             g = -1;
    if (g >= 0) m_last_wr = (g == 1);
    addr = (g == 1) ? (m_wr_buf * FS + m_wr_cnt) : (m_rd_buf * FS + m_rd_cnt);
    return g;
  endfunction

  function automatic void model_complete(input bit is_wr, output bit wd, output bit rdn);
    wd = 0; rdn = 0;
    if (is_wr) begin
      m_wr_cnt += BL;
      if (m_wr_cnt == FW) begin
        wd = 1; m_last_done = m_wr_buf; m_frame_valid = 1;
      end
    end else begin
      m_rd_cnt += BL;
      if (m_rd_cnt == FW) rdn = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_levels();
    wr_fifo_level = 16'(wr_level);
    rd_fifo_space = 16'(rd_level);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_cmd_valid", cmd_valid, 0);
    checkOutput("rst_cmd_write", cmd_write, 0);
    checkOutput("rst_cmd_addr", cmd_addr, 0);
    checkOutput("rst_wr_buf", wr_buf, 1);
    checkOutput("rst_rd_buf", rd_buf, 0);
    checkOutput("rst_wr_done", frame_write_done, 0);
    checkOutput("rst_rd_done", frame_read_done, 0);
  endtask

  task automatic expectIdle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput("idle_no_cmd", cmd_valid, 0);
    end
  endtask

  // Frame events are pulsed with both FIFOs starved so no grant can race the event.
  task automatic applyStimulus(input bit vin, input bit vout);
    wr_fifo_level = 16'd0;
    rd_fifo_space = 16'd0;
    vin_vs_pulse  = vin;
    vout_vs_pulse = vout;
    tick();
    vin_vs_pulse  = 1'b0;
    vout_vs_pulse = 1'b0;
    tick();
    if (vout) model_vout();
    if (vin)  model_vin();
    checkOutput("ev_wr_buf", wr_buf, m_wr_buf);
    checkOutput("ev_rd_buf", rd_buf, m_rd_buf);
    checkOutput("ev_no_cmd", cmd_valid, 0);
    drive_levels();
  endtask

  task automatic runBurst(input int stall, input bit vs_in_wait);
    int g, addr, n, d;
    bit exp_wd, exp_rd;
    g = model_grant(addr);
    if (g < 0) begin
      expectIdle(4);
      return;
    end
    for (int i = 0; i < 20 && cmd_valid !== 1'b1; i++) tick();
    checkOutput("cmd_valid", cmd_valid, 1);
    if (cmd_valid !== 1'b1) return;
    checkOutput("cmd_write", cmd_write, g);
    checkOutput("cmd_addr", cmd_addr, addr);
    checkOutput("cmd_len", cmd_len, BL - 1);
    n = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    for (int i = 0; i < n; i++) begin
      cmd_ready = 1'b0;
      tick();
      checkOutput("stall_valid", cmd_valid, 1);
      checkOutput("stall_write", cmd_write, g);
      checkOutput("stall_addr", cmd_addr, addr);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checkOutput("accept_valid", cmd_valid, 0);
    if (vs_in_wait) begin
      vin_vs_pulse  = 1'b1;
      vout_vs_pulse = 1'b1;
      tick();
      vin_vs_pulse  = 1'b0;
      vout_vs_pulse = 1'b0;
    end
    d = int'($urandom_range(0, 2));
    for (int i = 0; i < d; i++) tick();
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    model_complete(g == 1, exp_wd, exp_rd);
    checkOutput("frame_write_done", frame_write_done, exp_wd);
    checkOutput("frame_read_done", frame_read_done, exp_rd);
    if (vs_in_wait) begin
      tick();
      model_vout();
      model_vin();
      checkOutput("wait_ev_wr_buf", wr_buf, m_wr_buf);
      checkOutput("wait_ev_rd_buf", rd_buf, m_rd_buf);
      checkOutput("wait_ev_no_cmd", cmd_valid, 0);
    end
  endtask

  initial begin
    int dummy_addr, g;
    rst_n = 1'b0; ddr_init_done = 1'b0; cmd_ready = 1'b0; burst_done = 1'b0;
    vin_vs_pulse = 1'b0; vout_vs_pulse = 1'b0;
    drive_levels();
    model_reset();
    tick(); tick();
    checkReset();
    rst_n = 1'b1;
    tick();

    // Init gating: frame start ignored while controller not calibrated.
    wr_level = 100; drive_levels();
    vin_vs_pulse = 1'b1; tick(); vin_vs_pulse = 1'b0;
    expectIdle(5);
    checkOutput("gated_wr_buf", wr_buf, 1);
    ddr_init_done = 1'b1;
    expectIdle(4);
    $display("[TB] init gating done");

    // Basic write frame into buffer 1.
    applyStimulus(1, 0);
    wr_level = 8; rd_level = 0; drive_levels();
    for (int i = 0; i < 5; i++) runBurst(-1, 0);

    // Display picks up the completed frame.
    applyStimulus(0, 1);
    rd_level = 64; drive_levels();
    for (int i = 0; i < 5; i++) runBurst(-1, 0);
    $display("[TB] write/read frames done");

    // Round-robin with both directions eligible; also rotates the write buffer.
    applyStimulus(1, 1);
    wr_level = 200; rd_level = 200; drive_levels();
    for (int i = 0; i < 9; i++) runBurst(-1, 0);
    applyStimulus(1, 0);
    $display("[TB] round-robin and rotation done");

    // Events during WAIT with a long ready stall.
    wr_level = 200; rd_level = 200; drive_levels();
    runBurst(5, 1);
    runBurst(-1, 0);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 5) == 0)
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wr_level = ($urandom_range(0, 3) != 0) ? int'($urandom_range(4, 300)) : int'($urandom_range(0, 3));
      rd_level = ($urandom_range(0, 3) != 0) ? int'($urandom_range(4, 300)) : int'($urandom_range(0, 3));
      drive_levels();
      runBurst(-1, $urandom_range(0, 7) == 0);
    end
    $display("[TB] random traffic done");

    // Reset asserted while a burst is outstanding.
    applyStimulus(1, 0);
    wr_level = 100; rd_level = 0; drive_levels();
    for (int i = 0; i < 20 && cmd_valid !== 1'b1; i++) tick();
    checkOutput("pre_rst_cmd_valid", cmd_valid, 1);
    g = model_grant(dummy_addr);
    checkOutput("pre_rst_cmd_addr", cmd_addr, dummy_addr);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checkReset();
    rst_n = 1'b1;
    model_reset();
    burst_done = 1'b1; tick(); burst_done = 1'b0;
    checkOutput("post_rst_wr_done", frame_write_done, 0);
    checkOutput("post_rst_rd_done", frame_read_done, 0);
    expectIdle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
